flash_cache: RTL and testbench

Direct-mapped, read-only word cache between the CPU memory bus and the SPI flash controller. Hits are served from local storage in two cycles. Misses fetch one 32-bit word from the flash controller over its memory-bus port, fill the line, then respond. Writes are acknowledged and dropped, matching the flash controller's read-only behaviour.

---
 rtl/flash_cache_pkg.sv | 16 +
 rtl/flash_cache_store.sv | 45 ++++
 rtl/flash_cache.sv | 123 ++++++++++++
 tb/tb_flash_cache.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_cache_pkg.sv
// Shared types and geometry helpers for the flash_cache read-only word cache.
package flash_cache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RESPOND} state_t;

  localparam int FLASH_WORD_BYTES = 4;

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int addr_bits, input int lines);
    return addr_bits - $clog2(FLASH_WORD_BYTES) - $clog2(lines);
  endfunction

endpackage

// File: rtl/flash_cache_store.sv
// Line storage for flash_cache: valid/tag/data arrays, combinational lookup,
// one synchronous line write port and a synchronous invalidate-all.
module flash_cache_store
  import flash_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 18
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          invalidate,
  input  logic [IDX_W-1:0]              lookup_index,
  input  logic [TAG_W-1:0]              lookup_tag,
  output logic                          hit,
  output logic [FLASH_WORD_BYTES*8-1:0] hit_data,
  input  logic                          write_en,
  input  logic [IDX_W-1:0]              write_index,
  input  logic [TAG_W-1:0]              write_tag,
  input  logic [FLASH_WORD_BYTES*8-1:0] write_data
);

  localparam int WORD_W = FLASH_WORD_BYTES * 8;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [WORD_W-1:0] words [LINES];

  // Invalidate beats a coincident fill: the line stays invalid.
  always_ff @(posedge clk) begin
    if (reset || invalidate) valid <= '0;
    else if (write_en)       valid[write_index] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      tags[write_index]  <= write_tag;
      words[write_index] <= write_data;
    end
  end

  assign hit      = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
  assign hit_data = words[lookup_index];

endmodule

// File: rtl/flash_cache.sv
// Direct-mapped read-only word cache in front of the SPI flash controller.
// Optional statistics counters enabled by defining FLASH_CACHE_STATS_EN.
module flash_cache
  import flash_cache_pkg::*;
#(
  parameter int LINES     = 16,
  parameter int ADDR_BITS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  input  logic        invalidate_in,
  output logic [31:0] flash_address_out,
  output logic        flash_sel_out,
  output logic        flash_read_out,
  output logic [3:0]  flash_write_mask_out,
  output logic [31:0] flash_write_value_out,
  input  logic [31:0] flash_read_value_in,
  input  logic        flash_ready_in,
  output logic [31:0] hit_count_out,
  output logic [31:0] miss_count_out
);

  localparam int IDX_BITS = idx_bits(LINES);
  localparam int TAG_BITS = tag_bits(ADDR_BITS, LINES);

  state_t      state, state_next;
  logic [31:0] data_r;
  logic [31:0] fill_addr;
  logic        hit;
  logic [31:0] hit_data;
  logic        accept;
  logic        fill_done;
  logic        unused_inputs;

  assign unused_inputs = ^{address_in[31:ADDR_BITS], address_in[1:0],
                           write_mask_in, write_value_in};

  assign accept    = (state == IDLE) && sel_in && !ready_out;
  assign fill_done = (state == FILL) && flash_ready_in;

  flash_cache_store #(
    .LINES (LINES),
    .IDX_W (IDX_BITS),
    .TAG_W (TAG_BITS)
  ) store (
    .clk          (clk),
    .reset        (reset),
    .invalidate   (invalidate_in),
    .lookup_index (address_in[2 +: IDX_BITS]),
    .lookup_tag   (address_in[ADDR_BITS-1 : 2+IDX_BITS]),
    .hit          (hit),
    .hit_data     (hit_data),
    .write_en     (fill_done && !reset),
    .write_index  (fill_addr[2 +: IDX_BITS]),
    .write_tag    (fill_addr[ADDR_BITS-1 : 2+IDX_BITS]),
    .write_data   (flash_read_value_in)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (read_in && !hit) ? FILL : RESPOND;
      FILL:    if (flash_ready_in) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request is captured once at acceptance; address_in is not trusted afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r    <= '0;
      fill_addr <= '0;
    end else if (accept) begin
      data_r    <= (read_in && hit) ? hit_data : 32'h0;
      fill_addr <= {{(32-ADDR_BITS){1'b0}}, address_in[ADDR_BITS-1:2], 2'b00};
    end else if (fill_done) begin
      data_r <= flash_read_value_in;
    end
  end

  assign ready_out             = (state == RESPOND);
  assign read_value_out        = (ready_out && sel_in) ? data_r : 32'h0;
  assign flash_sel_out         = (state == FILL);
  assign flash_read_out        = flash_sel_out;
  assign flash_address_out     = fill_addr;
  assign flash_write_mask_out  = 4'h0;
  assign flash_write_value_out = 32'h0;

`ifdef FLASH_CACHE_STATS_EN
  logic [31:0] hits;
  logic [31:0] misses;

  always_ff @(posedge clk) begin
    if (reset) begin
      hits   <= '0;
      misses <= '0;
    end else if (accept && read_in) begin
      if (hit) hits   <= hits + 32'd1;
      else     misses <= misses + 32'd1;
    end
  end

  assign hit_count_out  = hits;
  assign miss_count_out = misses;
`else
  assign hit_count_out  = 32'h0;
  assign miss_count_out = 32'h0;
`endif

endmodule

// File: tb/tb_flash_cache.sv
// Self-checking bench for flash_cache: directed scenarios plus randomized
// traffic checked against a line-table model of the cache.
module tb_flash_cache;

  localparam int LINES = 16;

  logic        clk;
  logic        reset;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic        invalidate_in;
  logic [31:0] flash_address_out;
  logic        flash_sel_out;
  logic        flash_read_out;
  logic [3:0]  flash_write_mask_out;
  logic [31:0] flash_write_value_out;
  logic [31:0] flash_read_value_in;
  logic        flash_ready_in;
  logic [31:0] hit_count_out;
  logic [31:0] miss_count_out;

  flash_cache #(.LINES(LINES), .ADDR_BITS(24)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .address_in            (address_in),
    .sel_in                (sel_in),
    .read_in               (read_in),
    .read_value_out        (read_value_out),
    .write_mask_in         (write_mask_in),
    .write_value_in        (write_value_in),
    .ready_out             (ready_out),
    .invalidate_in         (invalidate_in),
    .flash_address_out     (flash_address_out),
    .flash_sel_out         (flash_sel_out),
    .flash_read_out        (flash_read_out),
    .flash_write_mask_out  (flash_write_mask_out),
    .flash_write_value_out (flash_write_value_out),
    .flash_read_value_in   (flash_read_value_in),
    .flash_ready_in        (flash_ready_in),
    .hit_count_out         (hit_count_out),
    .miss_count_out        (miss_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model: which word each line holds, plus counters.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_data  [LINES];
  int unsigned m_hits;
  int unsigned m_misses;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic model_clear_valid();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk_counters(input string name);
`ifdef FLASH_CACHE_STATS_EN
    chk({name, "_hits"}, hit_count_out, m_hits);
    chk({name, "_misses"}, miss_count_out, m_misses);
`else
    chk({name, "_hits"}, hit_count_out, 32'h0);
    chk({name, "_misses"}, miss_count_out, 32'h0);
`endif
    chk({name, "_wmask"}, 32'(flash_write_mask_out), 32'h0);
    chk({name, "_wvalue"}, flash_write_value_out, 32'h0);
  endtask

  function automatic logic [31:0] flash_word(input logic [31:0] addr);
    return (32'(addr[23:2]) * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  // One CPU transaction, entered and left at a negedge with the cache idle.
  task automatic request(input logic [31:0] addr, input bit rd, input logic [31:0] fill,
                         input bit inv_at_fill, input bit reset_mid,
                         output bit was_hit, output logic [31:0] rdata);
    int unsigned word, idx, tag;
    bit hit;
    int wait_n;
    word = 32'(addr[23:2]);
    idx  = word % LINES;
    tag  = word / LINES;
    hit  = rd && m_valid[idx] && (m_tag[idx] == tag);
    was_hit = hit;
    rdata   = 32'h0;
    address_in     = addr;
    read_in        = rd;
    sel_in         = 1'b1;
    write_mask_in  = 4'($urandom);
    write_value_in = $urandom;
    @(negedge clk);
    if (!rd || hit) begin
      if (hit) m_hits++;
      chk("ready_fast", 32'(ready_out), 32'h1);
      chk("rdata_fast", read_value_out, hit ? m_data[idx] : 32'h0);
      chk("fsel_quiet", 32'(flash_sel_out), 32'h0);
      rdata = read_value_out;
    end else begin
      m_misses++;
      chk("fsel_on", 32'(flash_sel_out), 32'h1);
      chk("fread_on", 32'(flash_read_out), 32'h1);
      chk("faddr", flash_address_out, {8'h00, addr[23:2], 2'b00});
      chk("ready_wait", 32'(ready_out), 32'h0);
      wait_n = $urandom_range(0, 4);
      repeat (wait_n) begin
        @(negedge clk);
        chk("fsel_hold", 32'(flash_sel_out), 32'h1);
        chk("ready_hold", 32'(ready_out), 32'h0);
      end
      if (reset_mid) begin
        reset  = 1'b1;
        sel_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear_valid();
        m_hits = 0;
        m_misses = 0;
        chk("rst_fsel", 32'(flash_sel_out), 32'h0);
        chk("rst_ready", 32'(ready_out), 32'h0);
        chk("rst_faddr", flash_address_out, 32'h0);
        flash_ready_in      = 1'b1;
        flash_read_value_in = $urandom;
        @(negedge clk);
        flash_ready_in = 1'b0;
        chk("stray_ready", 32'(ready_out), 32'h0);
        chk("stray_fsel", 32'(flash_sel_out), 32'h0);
        chk_counters("rst");
        return;
      end
      flash_ready_in      = 1'b1;
      flash_read_value_in = fill;
      invalidate_in       = inv_at_fill;
      @(negedge clk);
      flash_ready_in      = 1'b0;
      invalidate_in       = 1'b0;
      flash_read_value_in = $urandom;
      chk("fsel_off", 32'(flash_sel_out), 32'h0);
      chk("ready_fill", 32'(ready_out), 32'h1);
      chk("rdata_fill", read_value_out, fill);
      rdata = read_value_out;
      if (inv_at_fill) model_clear_valid();
      else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        m_data[idx]  = fill;
      end
    end
    sel_in     = 1'b0;
    read_in    = 1'($urandom);
    address_in = $urandom;
    @(negedge clk);
    chk("ready_pulse", 32'(ready_out), 32'h0);
    chk("rdata_nosel", read_value_out, 32'h0);
    chk_counters("txn");
  endtask

  task automatic idle_cycle(input bit stray, input bit inv);
    flash_ready_in      = stray;
    flash_read_value_in = $urandom;
    invalidate_in       = inv;
    @(negedge clk);
    flash_ready_in = 1'b0;
    invalidate_in  = 1'b0;
    if (inv) model_clear_valid();
    chk("idle_ready", 32'(ready_out), 32'h0);
    chk("idle_fsel", 32'(flash_sel_out), 32'h0);
  endtask

  bit          h;
  logic [31:0] d;
  logic [31:0] a;

  initial begin
    vectors = 0;
    miscompares = 0;
    m_hits = 0;
    m_misses = 0;
    model_clear_valid();
    reset = 1'b1;
    sel_in = 1'b0;
    read_in = 1'b0;
    address_in = 32'h0;
    write_mask_in = 4'h0;
    write_value_in = 32'h0;
    invalidate_in = 1'b0;
    flash_read_value_in = 32'h0;
    flash_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", 32'(ready_out), 32'h0);
    chk("reset_fsel", 32'(flash_sel_out), 32'h0);
    chk("reset_fread", 32'(flash_read_out), 32'h0);
    chk("reset_faddr", flash_address_out, 32'h0);
    chk("reset_rdata", read_value_out, 32'h0);
    chk_counters("reset");

    // Cold miss, then hit on the same word.
    request(32'h0000_0104, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, h, d);
    chk("dir_miss1_hit", 32'(h), 32'h0);
    chk("dir_miss1_data", d, 32'hDEADBEEF);
    request(32'h0000_0104, 1'b1, 32'h0, 1'b0, 1'b0, h, d);
    chk("dir_hit1_hit", 32'(h), 32'h1);
    chk("dir_hit1_data", d, 32'hDEADBEEF);

    // Write is acknowledged with zero data and leaves the line intact.
    request(32'h0000_0104, 1'b0, 32'h0, 1'b0, 1'b0, h, d);
    chk("dir_write_data", d, 32'h0);
    request(32'h0000_0104, 1'b1, 32'h0, 1'b0, 1'b0, h, d);
    chk("dir_after_write", d, 32'hDEADBEEF);

    // Same index, different tag evicts.
    request(32'h0000_0144, 1'b1, 32'h1111_2222, 1'b0, 1'b0, h, d);
    chk("dir_conflict_hit", 32'(h), 32'h0);
    request(32'h0000_0104, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, h, d);
    chk("dir_evicted_hit", 32'(h), 32'h0);

    // Invalidate coincident with fill completion.
    request(32'h0000_0208, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, h, d);
    chk("dir_inv_data", d, 32'hCAFEF00D);
    request(32'h0000_0208, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, h, d);
    chk("dir_inv_remiss", 32'(h), 32'h0);

    // Reset in the middle of a fill.
    request(32'h0000_030C, 1'b1, 32'h0, 1'b0, 1'b1, h, d);
    request(32'h0000_030C, 1'b1, 32'h3030_3030, 1'b0, 1'b0, h, d);
    chk("dir_rst_remiss", 32'(h), 32'h0);
    chk("dir_rst_data", d, 32'h3030_3030);

    // Randomized traffic over a small address pool so hits and conflicts occur.
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      a[23:0] = 24'(($urandom_range(0, 3) * 97) << 6) | 24'($urandom_range(0, 15) << 2)
              | 24'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) idle_cycle(1'($urandom), $urandom_range(0, 3) == 0);
      request(a, $urandom_range(0, 4) != 0, flash_word(a), $urandom_range(0, 15) == 0,
              $urandom_range(0, 39) == 0, h, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
